// File: rtl/key_conditioner.sv
// Pushbutton front end: synchronise, debounce, press/release strobes and menu chord.
// Define AUTOREPEAT_EN to build auto-repeat press strobes on KEY[1] and KEY[2].
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [3:0] KEY,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic       chord_menu
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    r_s1;
    logic [3:0]    r_s2;
    logic [3:0]    r_level;
    logic [3:0]    r_press;
    logic [3:0]    r_release;
    logic [CW-1:0] r_cnt [4];
    logic          r_chordTerm;
    logic          r_chord;
    logic [3:0]    w_accept;
    logic [3:0]    w_repeat;

    // KEY is active-low and asynchronous; invert before the two-flop synchroniser.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= ~KEY;
            r_s2 <= r_s1;
        end
    end

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < 4; i++) begin
            w_accept[i] = (r_s2[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if ((r_s2[i] == r_level[i]) || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
            r_level   <= r_level ^ w_accept;
            r_press   <= (w_accept & r_s2) | w_repeat;
            r_release <= w_accept & ~r_s2;
        end
    end

    // The chord strobe fires once per rise of the combined KEY[3:1] level.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_chordTerm <= 1'b0;
            r_chord     <= 1'b0;
        end else begin
            r_chordTerm <= &r_level[3:1];
            r_chord     <= (&r_level[3:1]) & ~r_chordTerm;
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int            RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW          = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rep [1:2];
    logic [2:1]    r_repeating;
    logic [2:1]    w_repHit;

    always_comb begin
        w_repeat = '0;
        w_repHit = '0;
        for (int i = 1; i <= 2; i++) begin
            w_repHit[i] = (r_rep[i] == (r_repeating[i] ? PERIOD_LAST : DELAY_LAST));
            w_repeat[i] = r_level[i] & ~r_level[3] & w_repHit[i];
        end
    end

    // Holding KEY[3] restarts the delay so the chord never scrolls the menu.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rep[1]    <= '0;
            r_rep[2]    <= '0;
            r_repeating <= '0;
        end else begin
            for (int i = 1; i <= 2; i++) begin
                if (!r_level[i] || r_level[3]) begin
                    r_rep[i]       <= '0;
                    r_repeating[i] <= 1'b0;
                end else if (w_repHit[i]) begin
                    r_rep[i]       <= '0;
                    r_repeating[i] <= 1'b1;
                end else begin
                    r_rep[i] <= r_rep[i] + RW'(1);
                end
            end
        end
    end
`else
    always_comb begin
        w_repeat = '0;
    end
`endif

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign chord_menu  = r_chord;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: vector table plus hand-written corner
// sequences, with expected strobes scheduled on a cycle-stamped scoreboard queue.
module tb_key_conditioner;
    localparam int DEB = 4;
    localparam int LAT = DEB + 2;

    logic       clk  = 1'b0;
    logic       rstN = 1'b0;
    logic [3:0] key  = 4'b0000;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic       chord_menu;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic       chord;
        logic [3:0] level;
    } event_t;

    typedef struct {
        logic [3:0] keyIn;
        int         hold;
        logic [3:0] expPress;
        logic [3:0] expRelease;
        logic [3:0] expLevel;
    } vec_t;

    event_t     sbQ[$];
    event_t     evt;
    logic [3:0] monLevel = 4'b0000;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rstN),
        .KEY        (key),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .chord_menu (chord_menu)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] k, output int t);
        @(negedge clk);
        key = k;
        t   = cyc;
    endtask

    task automatic expectAt(input int c, input logic [3:0] p, input logic [3:0] r,
                            input logic ch, input logic [3:0] lv);
        event_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.chord = ch;
        e.level = lv;
        sbQ.push_back(e);
    endtask

    task automatic drain();
        int guard = 0;
        while (sbQ.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d events still pending, expected 0", sbQ.size());
            sbQ.delete();
        end
        waitCycles(3);
    endtask

    // Every cycle, compare strobes against the scheduled event (or silence) and the level.
    always @(posedge clk) begin
        #1;
        if (!rstN) monLevel = 4'b0000;
        while (sbQ.size() != 0 && sbQ[0].cyc < cyc) begin
            evt = sbQ.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missedEvent: event due at cycle %0d, now cycle %0d", evt.cyc, cyc);
        end
        if (sbQ.size() != 0 && sbQ[0].cyc == cyc) begin
            evt = sbQ.pop_front();
            checkOutput("press", key_press, evt.press);
            checkOutput("release", key_release, evt.rel);
            checkOutput("chord", {3'b000, chord_menu}, {3'b000, evt.chord});
            monLevel = evt.level;
        end else begin
            checkOutput("idlePress", key_press, 4'b0000);
            checkOutput("idleRelease", key_release, 4'b0000);
            checkOutput("idleChord", {3'b000, chord_menu}, 4'b0000);
        end
        checkOutput("level", key_level, monLevel);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        int   t;
        int   t2;

        vecs[0] = '{4'b1101, 8, 4'b0010, 4'b0000, 4'b0010};
        vecs[1] = '{4'b1111, 8, 4'b0000, 4'b0010, 4'b0000};
        vecs[2] = '{4'b1110, 8, 4'b0001, 4'b0000, 4'b0001};
        vecs[3] = '{4'b1111, 8, 4'b0000, 4'b0001, 4'b0000};
        vecs[4] = '{4'b0101, 8, 4'b1010, 4'b0000, 4'b1010};
        vecs[5] = '{4'b1111, 8, 4'b0000, 4'b1010, 4'b0000};
        vecs[6] = '{4'b0110, 8, 4'b1001, 4'b0000, 4'b1001};
        vecs[7] = '{4'b0111, 8, 4'b0000, 4'b0001, 4'b1000};
        vecs[8] = '{4'b1110, 8, 4'b0001, 4'b1000, 4'b0001};
        vecs[9] = '{4'b1111, 8, 4'b0000, 4'b0001, 4'b0000};

        // Reset with every key held, then release reset: all four accepted together.
        rstN = 1'b0;
        key  = 4'b0000;
        waitCycles(3);
        checkOutput("resetLevel", key_level, 4'b0000);
        checkOutput("resetPress", key_press, 4'b0000);
        checkOutput("resetRelease", key_release, 4'b0000);
        checkOutput("resetChord", {3'b000, chord_menu}, 4'b0000);
        @(negedge clk);
        rstN = 1'b1;
        t    = cyc;
        expectAt(t + LAT,     4'b1111, 4'b0000, 1'b0, 4'b1111);
        expectAt(t + LAT + 1, 4'b0000, 4'b0000, 1'b1, 4'b1111);
        drain();
        applyStimulus(4'b1111, t);
        expectAt(t + LAT, 4'b0000, 4'b1111, 1'b0, 4'b0000);
        drain();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].keyIn, t);
            expectAt(t + LAT, vecs[i].expPress, vecs[i].expRelease, 1'b0, vecs[i].expLevel);
            waitCycles(vecs[i].hold);
        end
        drain();

        // Bounce: two 3-cycle lows separated by 2 highs never reach the threshold.
        applyStimulus(4'b1011, t);
        waitCycles(2);
        applyStimulus(4'b1111, t);
        waitCycles(1);
        applyStimulus(4'b1011, t);
        waitCycles(2);
        applyStimulus(4'b1111, t);
        waitCycles(12);
        checkOutput("bounceLevel", key_level, 4'b0000);

        // Shortest accepted pulse: 4 cycles low, release accepted 4 cycles after the press.
        applyStimulus(4'b1011, t);
        waitCycles(3);
        applyStimulus(4'b1111, t2);
        expectAt(t + LAT,  4'b0100, 4'b0000, 1'b0, 4'b0100);
        expectAt(t2 + LAT, 4'b0000, 4'b0100, 1'b0, 4'b0000);
        drain();

        // Chord formed over several cycles, held, released, then formed again at once.
        applyStimulus(4'b0111, t);
        waitCycles(1);
        applyStimulus(4'b0011, t2);
        waitCycles(1);
        applyStimulus(4'b0001, t2);
        expectAt(t + LAT,      4'b1000, 4'b0000, 1'b0, 4'b1000);
        expectAt(t + LAT + 2,  4'b0100, 4'b0000, 1'b0, 4'b1100);
        expectAt(t + LAT + 4,  4'b0010, 4'b0000, 1'b0, 4'b1110);
        expectAt(t + LAT + 5,  4'b0000, 4'b0000, 1'b1, 4'b1110);
        waitCycles(20);
        applyStimulus(4'b1111, t);
        expectAt(t + LAT, 4'b0000, 4'b1110, 1'b0, 4'b0000);
        drain();
        applyStimulus(4'b0001, t);
        expectAt(t + LAT,     4'b1110, 4'b0000, 1'b0, 4'b1110);
        expectAt(t + LAT + 1, 4'b0000, 4'b0000, 1'b1, 4'b1110);
        drain();
        applyStimulus(4'b1111, t);
        expectAt(t + LAT, 4'b0000, 4'b1110, 1'b0, 4'b0000);
        drain();

        // Reset pulse while KEY[0] is mid-debounce discards it; re-accepted afterwards.
        applyStimulus(4'b1110, t);
        waitCycles(2);
        rstN = 1'b0;
        waitCycles(2);
        rstN = 1'b1;
        t2   = cyc;
        expectAt(t2 + LAT, 4'b0001, 4'b0000, 1'b0, 4'b0001);
        drain();
        applyStimulus(4'b1111, t);
        expectAt(t + LAT, 4'b0000, 4'b0001, 1'b0, 4'b0000);
        drain();

`ifdef AUTOREPEAT_EN
        // Held KEY[1] repeats at +10 then every +5; held KEY[0] strobes once.
        applyStimulus(4'b1101, t);
        expectAt(t + LAT, 4'b0010, 4'b0000, 1'b0, 4'b0010);
        for (int r = t + LAT + 10; r <= t + 41; r += 5) begin
            expectAt(r, 4'b0010, 4'b0000, 1'b0, 4'b0010);
        end
        waitCycles(37);
        applyStimulus(4'b1111, t2);
        expectAt(t2 + LAT, 4'b0000, 4'b0010, 1'b0, 4'b0000);
        drain();
        applyStimulus(4'b1110, t);
        expectAt(t + LAT, 4'b0001, 4'b0000, 1'b0, 4'b0001);
        waitCycles(37);
        applyStimulus(4'b1111, t2);
        expectAt(t2 + LAT, 4'b0000, 4'b0001, 1'b0, 4'b0000);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
